// File: rtl/sc_scroll_pkg.sv
// sc_scroll_pkg
// Shared types and constants for the obstacle-scroll scheduler.
// Contents:
//   - scrollState_t : 4-bit FSM state encoding
//   - LEVEL_0..3    : speed-level codes; these select the scroll period in the ticker
//   - LEVEL_MAX     : saturation level
//   - TICK_W        : width of the shared run/pause tick counter
package sc_scroll_pkg;

    localparam int unsigned TICK_W = 26;

    localparam logic [1:0] LEVEL_0   = 2'd0;
    localparam logic [1:0] LEVEL_1   = 2'd1;
    localparam logic [1:0] LEVEL_2   = 2'd2;
    localparam logic [1:0] LEVEL_3   = 2'd3;
    localparam logic [1:0] LEVEL_MAX = LEVEL_3;

    typedef enum logic [3:0] {
        StReset     = 4'd0,
        StIdle      = 4'd1,
        StInitClear = 4'd2,
        StInitLoad  = 4'd3,
        StRun       = 4'd4,
        StShift     = 4'd5,
        StLoad      = 4'd6,
        StCheck     = 4'd7,
        StHit       = 4'd8,
        StPause     = 4'd9,
        StGameOver  = 4'd10
    } scrollState_t;

endpackage

// File: rtl/sc_scroll_ticker.sv
// sc_scroll_ticker
// Tick counter shared by the RUN and PAUSE phases. It counts up while it is enabled and sits at 0
// while it is disabled. terminal_o marks the last cycle of the selected period.
// Ports:
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   enable_i   : count this cycle; when low the counter is held at 0
//   pauseSel_i : 1 selects PAUSE_CYCLES, 0 selects the period for the current level
//   level_i    : speed level that selects TICK_L0..TICK_L3
//   terminal_o : counter equals period-1
module sc_scroll_ticker
    import sc_scroll_pkg::*;
#(
    parameter int unsigned TICK_L0      = 25_000_000,
    parameter int unsigned TICK_L1      = 18_750_000,
    parameter int unsigned TICK_L2      = 12_500_000,
    parameter int unsigned TICK_L3      = 6_250_000,
    parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       pauseSel_i,
    input  logic [1:0] level_i,
    output logic       terminal_o
);

    logic [TICK_W-1:0] tickQ;
    logic [TICK_W-1:0] period;

    always_comb begin
        period = TICK_W'(TICK_L0);
        if (pauseSel_i) begin
            period = TICK_W'(PAUSE_CYCLES);
        end else begin
            case (level_i)
                LEVEL_0: period = TICK_W'(TICK_L0);
                LEVEL_1: period = TICK_W'(TICK_L1);
                LEVEL_2: period = TICK_W'(TICK_L2);
                default: period = TICK_W'(TICK_L3);
            endcase
        end
    end

    assign terminal_o = (tickQ == (period - TICK_W'(1)));

    // Holding at 0 while disabled makes every RUN/PAUSE entry start from a fresh count.
    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            tickQ <= '0;
        end else begin
            tickQ <= tickQ + TICK_W'(1);
        end
    end

endmodule

// File: rtl/sc_statemachine_scroll.sv
// sc_statemachine_scroll
// Game-level scheduler for the obstacle shift-register bank. It issues the clear, load and shift
// strobes that scroll obstacle rows, advances the row-ROM pattern, raises the speed level, and
// manages lives and game-over from the collision comparator.
// Ports:
//   SC_STATEMACHINESCROLL_CLOCK_50          : system clock
//   SC_STATEMACHINESCROLL_RESET_InHigh      : synchronous active-high reset
//   SC_STATEMACHINESCROLL_startButton_InLow : debounced start, active low
//   SC_STATEMACHINESCROLL_collision_InLow   : player/obstacle overlap, active low
//   SC_STATEMACHINESCROLL_clear_OutLow      : clear obstacle bank (1-cycle pulse)
//   SC_STATEMACHINESCROLL_load_OutLow       : load top row from ROM (1-cycle pulse)
//   SC_STATEMACHINESCROLL_shift_OutLow      : shift rows down one (1-cycle pulse)
//   SC_STATEMACHINESCROLL_pattern_Out       : row-ROM address
//   SC_STATEMACHINESCROLL_level_Out         : current speed level
//   SC_STATEMACHINESCROLL_lives_Out         : remaining lives
//   SC_STATEMACHINESCROLL_gameover_Out      : high while in game over
module sc_statemachine_scroll
    import sc_scroll_pkg::*;
#(
    parameter int unsigned TICK_L0        = 25_000_000,
    parameter int unsigned TICK_L1        = 18_750_000,
    parameter int unsigned TICK_L2        = 12_500_000,
    parameter int unsigned TICK_L3        = 6_250_000,
    parameter int unsigned ROWS_PER_LEVEL = 32,
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned PAUSE_CYCLES   = 50_000_000
) (
    input  logic       SC_STATEMACHINESCROLL_CLOCK_50,
    input  logic       SC_STATEMACHINESCROLL_RESET_InHigh,
    input  logic       SC_STATEMACHINESCROLL_startButton_InLow,
    input  logic       SC_STATEMACHINESCROLL_collision_InLow,
    output logic       SC_STATEMACHINESCROLL_clear_OutLow,
    output logic       SC_STATEMACHINESCROLL_load_OutLow,
    output logic       SC_STATEMACHINESCROLL_shift_OutLow,
    output logic [2:0] SC_STATEMACHINESCROLL_pattern_Out,
    output logic [1:0] SC_STATEMACHINESCROLL_level_Out,
    output logic [1:0] SC_STATEMACHINESCROLL_lives_Out,
    output logic       SC_STATEMACHINESCROLL_gameover_Out
);

    localparam int unsigned ROW_W = (ROWS_PER_LEVEL > 1) ? $clog2(ROWS_PER_LEVEL) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_LEVEL - 1);
    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

    scrollState_t stateQ, stateD;
    logic [2:0] patternQ, patternD;
    logic [1:0] levelQ, levelD;
    logic [1:0] livesQ, livesD;
    logic [ROW_W-1:0] rowCntQ, rowCntD;
    logic clearNQ, loadNQ, shiftNQ, gameoverQ;
    logic tickDone;

    sc_scroll_ticker #(
        .TICK_L0      (TICK_L0),
        .TICK_L1      (TICK_L1),
        .TICK_L2      (TICK_L2),
        .TICK_L3      (TICK_L3),
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) u_ticker (
        .clk_i      (SC_STATEMACHINESCROLL_CLOCK_50),
        .reset_i    (SC_STATEMACHINESCROLL_RESET_InHigh),
        .enable_i   ((stateQ == StRun) || (stateQ == StPause)),
        .pauseSel_i (stateQ == StPause),
        .level_i    (levelQ),
        .terminal_o (tickDone)
    );

    always_comb begin
        stateD   = stateQ;
        patternD = patternQ;
        levelD   = levelQ;
        livesD   = livesQ;
        rowCntD  = rowCntQ;
        case (stateQ)
            StReset: stateD = StIdle;
            StIdle: begin
                if (!SC_STATEMACHINESCROLL_startButton_InLow) begin
                    stateD   = StInitClear;
                    patternD = 3'd0;
                    levelD   = LEVEL_0;
                    livesD   = LIVES_RST;
                    rowCntD  = '0;
                end
            end
            StInitClear: stateD = StInitLoad;
            StInitLoad:  stateD = StRun;
            StRun: begin
                // A collision wins over the end of the scroll period.
                if (!SC_STATEMACHINESCROLL_collision_InLow) begin
                    stateD = StHit;
                    livesD = livesQ - 2'd1;
                end else if (tickDone) begin
                    stateD = StShift;
                end
            end
            StShift: begin
                // Advance on entry to LOAD so the new top row is fetched from the next pattern.
                stateD   = StLoad;
                patternD = patternQ + 3'd1;
                if (rowCntQ == ROW_LAST) begin
                    rowCntD = '0;
                    if (levelQ != LEVEL_MAX) begin
                        levelD = levelQ + 2'd1;
                    end
                end else begin
                    rowCntD = rowCntQ + ROW_W'(1);
                end
            end
            StLoad: stateD = StCheck;
            StCheck: begin
                if (!SC_STATEMACHINESCROLL_collision_InLow) begin
                    stateD = StHit;
                    livesD = livesQ - 2'd1;
                end else begin
                    stateD = StRun;
                end
            end
            // Lives were already decremented on entry, so zero here means the last life is gone.
            StHit: stateD = (livesQ == 2'd0) ? StGameOver : StPause;
            StPause: begin
                if (tickDone) begin
                    stateD = StInitLoad;
                end
            end
            StGameOver: begin
                if (SC_STATEMACHINESCROLL_startButton_InLow) begin
                    stateD = StIdle;
                end
            end
            default: begin
                stateD   = StIdle;
                patternD = 3'd0;
                levelD   = LEVEL_0;
                livesD   = LIVES_RST;
                rowCntD  = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state and registered, giving glitch-free Moore outputs.
    always_ff @(posedge SC_STATEMACHINESCROLL_CLOCK_50) begin
        if (SC_STATEMACHINESCROLL_RESET_InHigh) begin
            stateQ    <= StReset;
            patternQ  <= 3'd0;
            levelQ    <= LEVEL_0;
            livesQ    <= LIVES_RST;
            rowCntQ   <= '0;
            clearNQ   <= 1'b1;
            loadNQ    <= 1'b1;
            shiftNQ   <= 1'b1;
            gameoverQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            patternQ  <= patternD;
            levelQ    <= levelD;
            livesQ    <= livesD;
            rowCntQ   <= rowCntD;
            clearNQ   <= !((stateD == StInitClear) || (stateD == StHit));
            loadNQ    <= !((stateD == StInitLoad) || (stateD == StLoad));
            shiftNQ   <= (stateD != StShift);
            gameoverQ <= (stateD == StGameOver);
        end
    end

    assign SC_STATEMACHINESCROLL_clear_OutLow = clearNQ;
    assign SC_STATEMACHINESCROLL_load_OutLow  = loadNQ;
    assign SC_STATEMACHINESCROLL_shift_OutLow = shiftNQ;
    assign SC_STATEMACHINESCROLL_pattern_Out  = patternQ;
    assign SC_STATEMACHINESCROLL_level_Out    = levelQ;
    assign SC_STATEMACHINESCROLL_lives_Out    = livesQ;
    assign SC_STATEMACHINESCROLL_gameover_Out = gameoverQ;

endmodule
